// File: rtl/sort_pkg.sv
// Shared definitions for the in-place bubble-sort memory master:
// default widths and the controller state encoding.
package sort_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DEPTH  = 32;
  localparam int DEF_CNT_W  = 6;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CHECK,
    S_LD_A,
    S_LD_B,
    S_CMP,
    S_WR_LO,
    S_WR_HI,
    S_NEXT,
    S_FIN
  } state_t;

endpackage

// File: rtl/sort_mem_master.sv
// Bubble-sort engine that owns the data-memory port while busy, sorting
// count words at base_addr ascending (unsigned) with early exit on a clean pass.
module sort_mem_master
  import sort_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  count,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  swap_count
);

  state_t state, state_nx;

  logic [ADDR_W-1:0] base_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  j_q;
  logic [CNT_W-1:0]  pass_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic              swapped_q;
  logic              err_q;
  logic [CNT_W-1:0]  swap_q;

  logic [ADDR_W-1:0] addr_lo;
  logic [ADDR_W-1:0] addr_hi;
  logic [ADDR_W:0]   span;
  logic [CNT_W:0]    j_inc;
  logic [CNT_W:0]    limit;
  logic              too_short;
  logic              too_far;
  logic              more_in_pass;
  logic              last_pass;

  assign addr_lo   = base_q + ADDR_W'(j_q);
  assign addr_hi   = addr_lo + ADDR_W'(1);
  // One extra bit so a base near the top of the address space cannot wrap past the check.
  assign span      = {1'b0, base_q} + (ADDR_W+1)'(cnt_q);
  assign too_short = cnt_q < CNT_W'(2);
  assign too_far   = span > (ADDR_W+1)'(DEPTH);

  assign j_inc        = {1'b0, j_q} + (CNT_W+1)'(1);
  assign limit        = {1'b0, cnt_q} - (CNT_W+1)'(1) - {1'b0, pass_q};
  assign more_in_pass = j_inc < limit;
  assign last_pass    = ({1'b0, pass_q} + (CNT_W+1)'(1)) == ({1'b0, cnt_q} - (CNT_W+1)'(1));

  assign err        = err_q;
  assign swap_count = swap_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q    <= '0;
      cnt_q     <= '0;
      j_q       <= '0;
      pass_q    <= '0;
      a_q       <= '0;
      b_q       <= '0;
      swapped_q <= 1'b0;
      err_q     <= 1'b0;
      swap_q    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            base_q <= base_addr;
            cnt_q  <= count;
            swap_q <= '0;
            err_q  <= 1'b0;
          end
        end
        S_CHECK: begin
          if (!too_short) begin
            if (too_far) begin
              err_q <= 1'b1;
            end else begin
              pass_q    <= '0;
              j_q       <= '0;
              swapped_q <= 1'b0;
            end
          end
        end
        S_LD_A: a_q <= mem_rdata;
        S_LD_B: b_q <= mem_rdata;
        S_WR_HI: begin
          swapped_q <= 1'b1;
          if (swap_q != '1) begin
            swap_q <= swap_q + CNT_W'(1);
          end
        end
        S_NEXT: begin
          if (more_in_pass) begin
            j_q <= j_q + CNT_W'(1);
          end else if (swapped_q && !last_pass) begin
            pass_q    <= pass_q + CNT_W'(1);
            j_q       <= '0;
            swapped_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Port outputs are decoded purely from registered state so they settle cleanly each cycle.
  always_comb begin
    state_nx  = state;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nx = S_CHECK;
      end
      S_CHECK: begin
        busy = 1'b1;
        if (too_short || too_far) state_nx = S_FIN;
        else                      state_nx = S_LD_A;
      end
      S_LD_A: begin
        busy     = 1'b1;
        mem_addr = addr_lo;
        state_nx = S_LD_B;
      end
      S_LD_B: begin
        busy     = 1'b1;
        mem_addr = addr_hi;
        state_nx = S_CMP;
      end
      S_CMP: begin
        busy = 1'b1;
        if (a_q > b_q) state_nx = S_WR_LO;
        else           state_nx = S_NEXT;
      end
      S_WR_LO: begin
        busy      = 1'b1;
        mem_addr  = addr_lo;
        mem_wdata = b_q;
        mem_we    = 1'b1;
        state_nx  = S_WR_HI;
      end
      S_WR_HI: begin
        busy      = 1'b1;
        mem_addr  = addr_hi;
        mem_wdata = a_q;
        mem_we    = 1'b1;
        state_nx  = S_NEXT;
      end
      S_NEXT: begin
        busy = 1'b1;
        if (more_in_pass)                  state_nx = S_LD_A;
        else if (!swapped_q || last_pass)  state_nx = S_FIN;
        else                               state_nx = S_LD_A;
      end
      S_FIN: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule
